// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - ULX3S LED mode sequencer with debounced next/pause buttons and a clock-enable display tick.

module led_mode_button #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds the number of consecutive samples that disagreed with
  // the accepted level; the sample that finds it at DEBOUNCE_CYCLES commits the flip.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;
endmodule

module led_mode_sequencer #(
  parameter int TICK_DIV        = 16777216,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       tick
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [6:0]    pattern_q, pattern_d;
  logic          heart_q, heart_d;
  logic          paused_q, paused_d;
  logic          dir_right_q, dir_right_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          next_press, pause_press;
  logic          tick_w;

  led_mode_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk_i   (clk_25mhz),
    .reset_i (reset),
    .raw_i   (btn_next),
    .press_o (next_press)
  );

  led_mode_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pause (
    .clk_i   (clk_25mhz),
    .reset_i (reset),
    .raw_i   (btn_pause),
    .press_o (pause_press)
  );

  assign tick_w = !paused_q && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    heart_d     = heart_q;
    paused_d    = paused_q;
    dir_right_d = dir_right_q;
    presc_d     = presc_q;

    if (tick_w) begin
      presc_d = '0;
    end else if (!paused_q) begin
      presc_d = presc_q + PW'(1);
    end

    if (tick_w) begin
      heart_d = ~heart_q;
      unique case (mode_q)
        MODE_COUNT: pattern_d = pattern_q + 7'd1;
        MODE_SHIFT: pattern_d = {pattern_q[5:0], pattern_q[6]};
        MODE_BOUNCE: begin
          pattern_d = dir_right_q ? {1'b0, pattern_q[6:1]} : {pattern_q[5:0], 1'b0};
          if (pattern_d[6]) dir_right_d = 1'b1;
          if (pattern_d[0]) dir_right_d = 1'b0;
        end
        MODE_BLINK: pattern_d = ~pattern_q;
        default:    pattern_d = pattern_q;
      endcase
    end

    // A mode change overrides the tick's pattern update but not its heartbeat toggle.
    if (next_press) begin
      mode_d      = mode_e'(mode_q + 2'd1);
      presc_d     = '0;
      dir_right_d = 1'b0;
      unique case (mode_d)
        MODE_COUNT: pattern_d = 7'h00;
        MODE_BLINK: pattern_d = 7'h55;
        default:    pattern_d = 7'h01;
      endcase
    end

    if (pause_press) paused_d = ~paused_q;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      mode_q      <= MODE_COUNT;
      pattern_q   <= '0;
      heart_q     <= 1'b0;
      paused_q    <= 1'b0;
      dir_right_q <= 1'b0;
      presc_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      heart_q     <= heart_d;
      paused_q    <= paused_d;
      dir_right_q <= dir_right_d;
      presc_q     <= presc_d;
    end
  end

  assign led    = {heart_q, pattern_q};
  assign mode   = mode_q;
  assign paused = paused_q;
  assign tick   = tick_w;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - Self-checking bench for led_mode_sequencer with a behavioural reference model.

module tb_led_mode_sequencer;
  localparam int TD   = 4;
  localparam int DB   = 3;
  localparam int MASK = (1 << (DB + 1)) - 1;

  logic       clk_25mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       btn_next  = 1'b0;
  logic       btn_pause = 1'b0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       tick;

  always #5 clk_25mhz = ~clk_25mhz;

  led_mode_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_pause (btn_pause),
    .led       (led),
    .mode      (mode),
    .paused    (paused),
    .tick      (tick)
  );

  typedef struct {
    bit rst;
    bit nx;
    bit pz;
    int n;
    int led;
    int mode;
    int paused;
    int tick;
  } vec_t;

  vec_t vt[9];
  int n_cmp = 0;
  int n_bad = 0;

  int m_mode = 0, m_pat = 0, m_hb = 0, m_paused = 0, m_phase = 0, m_k = 0;
  int rh[2], sh[2], lvl[2], prs[2];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_advance();
    case (m_mode)
      0: m_pat = (m_pat + 1) % 128;
      1: m_pat = ((m_pat << 1) | (m_pat >> 6)) & 127;
      2: begin
        m_k   = (m_k + 1) % 12;
        m_pat = 1 << ((m_k <= 6) ? m_k : 12 - m_k);
      end
      default: m_pat = m_pat ^ 127;
    endcase
  endtask

  task automatic model_step(input bit rst, input bit rn, input bit rp);
    int t;
    int raw[2];
    int s;
    if (rst) begin
      m_mode = 0; m_pat = 0; m_hb = 0; m_paused = 0; m_phase = 0; m_k = 0;
      for (int b = 0; b < 2; b++) begin
        rh[b] = 0; sh[b] = 0; lvl[b] = 0; prs[b] = 0;
      end
      return;
    end
    t = (m_paused == 0 && m_phase == TD - 1) ? 1 : 0;
    if (prs[0] != 0) m_phase = 0;
    else if (m_paused == 0) m_phase = (m_phase + 1) % TD;
    if (t != 0) begin
      m_hb = m_hb ^ 1;
      if (prs[0] == 0) model_advance();
    end
    if (prs[0] != 0) begin
      m_mode = (m_mode + 1) % 4;
      m_k    = 0;
      case (m_mode)
        0:       m_pat = 0;
        3:       m_pat = 'h55;
        default: m_pat = 1;
      endcase
    end
    if (prs[1] != 0) m_paused = m_paused ^ 1;
    // A level is accepted once the last DB+1 synchronized samples all disagree with it.
    raw[0] = int'(rn);
    raw[1] = int'(rp);
    for (int b = 0; b < 2; b++) begin
      rh[b]  = ((rh[b] << 1) | raw[b]) & 7;
      s      = (rh[b] >> 2) & 1;
      sh[b]  = ((sh[b] << 1) | s) & MASK;
      prs[b] = 0;
      if ((lvl[b] == 0 && sh[b] == MASK) || (lvl[b] == 1 && sh[b] == 0)) begin
        lvl[b] = lvl[b] ^ 1;
        prs[b] = lvl[b];
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit nx, input bit pz);
    @(negedge clk_25mhz);
    reset     = rst;
    btn_next  = nx;
    btn_pause = pz;
    @(posedge clk_25mhz);
    model_step(rst, nx, pz);
    #1;
    check("model.led", int'(led), (m_hb << 7) | m_pat);
    check("model.mode", int'(mode), m_mode);
    check("model.paused", int'(paused), m_paused);
    check("model.tick", int'(tick), (m_paused == 0 && m_phase == TD - 1) ? 1 : 0);
  endtask

  task automatic run(input int n, input bit nx, input bit pz);
    for (int i = 0; i < n; i++) cyc(1'b0, nx, pz);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 2,  'h00, 0, 0, 0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 12, 'h83, 0, 0, 0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 10, 'h01, 1, 0, 1};
    vt[3] = '{1'b0, 1'b0, 1'b0, 4,  'h82, 1, 0, 1};
    vt[4] = '{1'b0, 1'b0, 1'b1, 8,  'h88, 1, 1, 0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 20, 'h88, 1, 1, 0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 6,  'h88, 1, 1, 0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 2,  'h88, 1, 0, 1};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1,  'h10, 1, 0, 0};

    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < vt[r].n; i++) cyc(vt[r].rst, vt[r].nx, vt[r].pz);
      check($sformatf("vec%0d.led", r), int'(led), vt[r].led);
      check($sformatf("vec%0d.mode", r), int'(mode), vt[r].mode);
      check($sformatf("vec%0d.paused", r), int'(paused), vt[r].paused);
      check($sformatf("vec%0d.tick", r), int'(tick), vt[r].tick);
    end

    // Short glitch on next must not change the mode.
    run(2, 1'b1, 1'b0);
    run(50, 1'b0, 1'b0);
    check("glitch.mode", int'(mode), 1);

    // Next press landing in the same cycle as a tick at COUNT pattern 05.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run(17, 1'b0, 1'b0);
    run(6, 1'b1, 1'b0);
    check("align.pre_tick", int'(tick), 1);
    check("align.pre_led", int'(led), 'h85);
    run(1, 1'b1, 1'b0);
    check("align.led", int'(led), 'h01);
    check("align.mode", int'(mode), 1);

    // Simultaneous next and pause presses, then next while paused into BLINK.
    run(6, 1'b0, 1'b0);
    run(7, 1'b1, 1'b1);
    run(6, 1'b0, 1'b0);
    check("both.pattern", int'(led[6:0]), 'h01);
    check("both.mode", int'(mode), 2);
    check("both.paused", int'(paused), 1);
    check("both.tick", int'(tick), 0);
    run(7, 1'b1, 1'b0);
    check("blink.pattern", int'(led[6:0]), 'h55);
    check("blink.mode", int'(mode), 3);
    check("blink.paused", int'(paused), 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("rst.led", int'(led), 'h00);
    check("rst.mode", int'(mode), 0);
    check("rst.paused", int'(paused), 0);
    check("rst.tick", int'(tick), 0);

    for (int s = 0; s < 300; s++) begin
      int  n;
      bit  nx, pz, rs;
      n  = int'($urandom_range(1, 14));
      nx = ($urandom_range(0, 3) == 0);
      pz = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < n; i++) cyc(rs && (i == 0), nx, pz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
